psram_qpi_responder: RTL and testbench

PSRAM_QPI_RESPONDER -- requirements
Module: psram_qpi_responder

---
 rtl/memctrl_pkg.sv | 25 ++
 rtl/psram_array.sv | 24 ++
 rtl/psram_qpi_responder.sv | 208 ++++++++++++++++++++
 tb/tb_psram_qpi_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_pkg.sv
// Shared PSRAM command opcodes and responder state encoding, also used by memCtrl.
// Pure declarations: no latency, no flow control.
package memctrl_pkg;

    localparam logic [7:0] OP_QPI_ENTER = 8'h35;
    localparam logic [7:0] OP_QPI_WRITE = 8'h38;
    localparam logic [7:0] OP_QPI_READ  = 8'hEB;
    localparam logic [7:0] OP_QPI_EXIT  = 8'hF5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI_CMD,
        ST_QPI_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_IGNORE
    } psram_state_t;

    function automatic logic txn_active(input psram_state_t s);
        return (s != ST_IDLE) && (s != ST_IGNORE);
    endfunction

endpackage

// File: rtl/psram_array.sv
// Byte storage for the PSRAM responder: one write port, one registered read port.
// Read data appears one clk after rd_addr; writes always accepted, no backpressure.
module psram_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    logic [7:0] mem [2**ADDR_BITS];

    // Contents are deliberately not reset so bursts survive a controller reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/psram_qpi_responder.sv
// PSRAM SPI/QPI target: decodes enter/exit-QPI, quad write and quad read with wait cycles.
// sclk edges seen 3 clk after the pin; read nibbles launched on falling edges, no backpressure.
module psram_qpi_responder
    import memctrl_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic [3:0] data_oe,
    output logic       qpi_mode,
    output logic       active
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

    psram_state_t         state;
    logic                 sclk_s1, sclk_s2, sclk_prev;
    logic                 cs_s1, cs_s2, cs_prev;
    logic [3:0]           din_s1, din_s2;
    logic [7:0]           cnt;
    logic [6:0]           cmd_sr;
    logic                 is_write;
    logic                 nib_lo;
    logic [3:0]           wr_hi;
    logic [ADDR_BITS-1:0] addr;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [7:0]           wr_data;
    logic [7:0]           rd_data;

    logic       sclk_rise, sclk_fall, cs_fall;
    logic [7:0] spi_op, qpi_op;

    // data_in passes through the same two stages as sclk so it stays aligned with the edge.
    assign sclk_rise = sclk_s2 & ~sclk_prev;
    assign sclk_fall = ~sclk_s2 & sclk_prev;
    assign cs_fall   = cs_prev & ~cs_s2;
    assign spi_op    = {cmd_sr[6:0], din_s2[0]};
    assign qpi_op    = {cmd_sr[3:0], din_s2};

    psram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            // cs sync clears low so a chip select held low through reset cannot start a transaction.
            cs_s1     <= 1'b0;
            cs_s2     <= 1'b0;
            cs_prev   <= 1'b0;
            din_s1    <= 4'h0;
            din_s2    <= 4'h0;
            cnt       <= 8'd0;
            cmd_sr    <= 7'd0;
            is_write  <= 1'b0;
            nib_lo    <= 1'b0;
            wr_hi     <= 4'h0;
            addr      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            data_out  <= 4'h0;
            data_oe   <= 4'h0;
            qpi_mode  <= 1'b0;
            active    <= 1'b0;
        end else begin
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            cs_s1     <= cs_n;
            cs_s2     <= cs_s1;
            cs_prev   <= cs_s2;
            din_s1    <= data_in;
            din_s2    <= din_s1;
            wr_en     <= 1'b0;
            active    <= txn_active(state);

            if (state != ST_IDLE && cs_s2) begin
                state    <= ST_IDLE;
                data_oe  <= 4'h0;
                data_out <= 4'h0;
                cnt      <= 8'd0;
                nib_lo   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        data_oe <= 4'h0;
                        if (cs_fall) begin
                            state  <= qpi_mode ? ST_QPI_CMD : ST_SPI_CMD;
                            cnt    <= 8'd0;
                            nib_lo <= 1'b0;
                        end
                    end
                    ST_SPI_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= {cmd_sr[5:0], din_s2[0]};
                            cnt    <= cnt + 8'd1;
                            if (cnt == 8'd7) begin
                                state <= ST_IGNORE;
                                if (spi_op == OP_QPI_ENTER) begin
                                    qpi_mode <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_QPI_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= {cmd_sr[2:0], din_s2};
                            cnt    <= cnt + 8'd1;
                            if (cnt == 8'd1) begin
                                cnt <= 8'd0;
                                case (qpi_op)
                                    OP_QPI_WRITE: begin
                                        state    <= ST_ADDR;
                                        is_write <= 1'b1;
                                    end
                                    OP_QPI_READ: begin
                                        state    <= ST_ADDR;
                                        is_write <= 1'b0;
                                    end
                                    OP_QPI_EXIT: begin
                                        state    <= ST_IGNORE;
                                        qpi_mode <= 1'b0;
                                    end
                                    default: state <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            // Shifting through an ADDR_BITS register keeps only the low address bits.
                            addr <= ADDR_BITS'({addr, din_s2});
                            cnt  <= cnt + 8'd1;
                            if (cnt == 8'd5) begin
                                cnt    <= 8'd0;
                                nib_lo <= 1'b0;
                                if (is_write) begin
                                    state <= ST_WR_DATA;
                                end else if (WAIT_CYCLES == 0) begin
                                    state   <= ST_RD_DATA;
                                    data_oe <= 4'hF;
                                end else begin
                                    state <= ST_WAIT;
                                end
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (sclk_rise) begin
                            cnt <= cnt + 8'd1;
                            if (cnt == WAIT_LAST) begin
                                state   <= ST_RD_DATA;
                                data_oe <= 4'hF;
                                nib_lo  <= 1'b0;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (sclk_rise) begin
                            if (!nib_lo) begin
                                wr_hi  <= din_s2;
                                nib_lo <= 1'b1;
                            end else begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= {wr_hi, din_s2};
                                addr    <= addr + 1'b1;
                                nib_lo  <= 1'b0;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        data_oe <= 4'hF;
                        if (sclk_fall) begin
                            if (!nib_lo) begin
                                data_out <= rd_data[7:4];
                                nib_lo   <= 1'b1;
                            end else begin
                                data_out <= rd_data[3:0];
                                addr     <= addr + 1'b1;
                                nib_lo   <= 1'b0;
                            end
                        end
                    end
                    ST_IGNORE: data_oe <= 4'h0;
                    default:   state   <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: SPI enable, QPI write/read, wrap, abort, reset.
// Initiator is modelled with sclk at 1/12 of clk; outputs sampled 1 ns after posedge clk.
module tb_psram_qpi_responder;
    import memctrl_pkg::*;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       cs_n;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic [3:0] data_oe;
    logic       qpi_mode;
    logic       active;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] oe_acc;

    always #5 clk = ~clk;

    psram_qpi_responder #(.ADDR_BITS(10), .WAIT_CYCLES(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .qpi_mode (qpi_mode),
        .active   (active)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk period; outputs are sampled just before the rising edge, as the initiator would.
    task automatic sclk_cycle(input logic [3:0] nib, output logic [3:0] seen_dat, output logic [3:0] seen_oe);
        data_in = nib;
        wait_clk(HALF);
        seen_dat = data_out;
        seen_oe  = data_oe;
        oe_acc   = oe_acc | data_oe;
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    task automatic start_txn();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic end_txn();
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic spi_byte(input logic [7:0] op);
        logic [3:0] d, o;
        for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, op[i]}, d, o);
    endtask

    task automatic qpi_hdr(input logic [7:0] op, input logic [23:0] a);
        logic [3:0] d, o;
        sclk_cycle(op[7:4], d, o);
        sclk_cycle(op[3:0], d, o);
        for (int i = 5; i >= 0; i--) sclk_cycle(a[i*4 +: 4], d, o);
    endtask

    task automatic write_burst(input logic [23:0] a, input logic [23:0] bytes, input int n);
        logic [3:0] d, o;
        start_txn();
        qpi_hdr(OP_QPI_WRITE, a);
        for (int k = 0; k < n; k++) begin
            sclk_cycle(bytes[23-8*k -: 4], d, o);
            sclk_cycle(bytes[19-8*k -: 4], d, o);
        end
        end_txn();
    endtask

    task automatic test_reset();
        reset = 1'b0; cs_n = 1'b1; sclk = 1'b0; data_in = 4'h0; oe_acc = 4'h0;
        wait_clk(4);
        n_checks++; if (data_oe !== 4'h0) begin n_fail++; $display("FAIL reset_oe: got %h expected 0", data_oe); end
        n_checks++; if (data_out !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", data_out); end
        n_checks++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL reset_qpi: got %b expected 0", qpi_mode); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
        n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
        reset = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_spi_enable();
        oe_acc = 4'h0;
        start_txn();
        n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL spi_active: got %b expected 1", active); end
        spi_byte(OP_QPI_ENTER);
        wait_clk(6);
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL spi_ignore_active: got %b expected 0", active); end
        end_txn();
        n_checks++; if (qpi_mode !== 1'b1) begin n_fail++; $display("FAIL spi_qpi_mode: got %b expected 1", qpi_mode); end
        n_checks++; if (oe_acc !== 4'h0) begin n_fail++; $display("FAIL spi_oe: got %h expected 0", oe_acc); end
    endtask

    task automatic test_write();
        write_burst(24'h000010, 24'hA53C00, 2);
        n_checks++; if (dut.u_array.mem[16] !== 8'hA5) begin n_fail++; $display("FAIL wr_0x10: got %h expected a5", dut.u_array.mem[16]); end
        n_checks++; if (dut.u_array.mem[17] !== 8'h3C) begin n_fail++; $display("FAIL wr_0x11: got %h expected 3c", dut.u_array.mem[17]); end
    endtask

    task automatic test_read();
        logic [3:0] d, o;
        logic [15:0] exp_n;
        exp_n  = 16'hA53C;
        oe_acc = 4'h0;
        start_txn();
        qpi_hdr(OP_QPI_READ, 24'h000010);
        for (int i = 0; i < 6; i++) sclk_cycle(4'h0, d, o);
        n_checks++; if (oe_acc !== 4'h0) begin n_fail++; $display("FAIL rd_oe_before_data: got %h expected 0", oe_acc); end
        for (int i = 0; i < 4; i++) begin
            sclk_cycle(4'h0, d, o);
            n_checks++; if (d !== exp_n[15-4*i -: 4]) begin n_fail++; $display("FAIL rd_nibble%0d: got %h expected %h", i, d, exp_n[15-4*i -: 4]); end
            n_checks++; if (o !== 4'hF) begin n_fail++; $display("FAIL rd_oe%0d: got %h expected f", i, o); end
        end
        end_txn();
        n_checks++; if (data_oe !== 4'h0) begin n_fail++; $display("FAIL rd_oe_after: got %h expected 0", data_oe); end
    endtask

    task automatic test_wrap();
        write_burst(24'h0003FF, 24'h112233, 3);
        n_checks++; if (dut.u_array.mem[1023] !== 8'h11) begin n_fail++; $display("FAIL wrap_3ff: got %h expected 11", dut.u_array.mem[1023]); end
        n_checks++; if (dut.u_array.mem[0] !== 8'h22) begin n_fail++; $display("FAIL wrap_000: got %h expected 22", dut.u_array.mem[0]); end
        n_checks++; if (dut.u_array.mem[1] !== 8'h33) begin n_fail++; $display("FAIL wrap_001: got %h expected 33", dut.u_array.mem[1]); end
    endtask

    task automatic test_abort();
        logic [3:0] d, o;
        write_burst(24'h000020, 24'h770000, 1);
        start_txn();
        qpi_hdr(OP_QPI_WRITE, 24'h000020);
        sclk_cycle(4'hE, d, o);
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(4);
        n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d expected IDLE", dut.state); end
        wait_clk(4);
        n_checks++; if (dut.u_array.mem[32] !== 8'h77) begin n_fail++; $display("FAIL abort_byte: got %h expected 77", dut.u_array.mem[32]); end
        n_checks++; if (qpi_mode !== 1'b1) begin n_fail++; $display("FAIL abort_qpi_kept: got %b expected 1", qpi_mode); end
    endtask

    task automatic test_qpi_exit();
        logic [3:0] d, o;
        start_txn();
        sclk_cycle(4'hF, d, o);
        sclk_cycle(4'h5, d, o);
        end_txn();
        n_checks++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL qpi_exit: got %b expected 0", qpi_mode); end
        start_txn();
        spi_byte(8'h9F);
        end_txn();
        n_checks++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL spi_other_op: got %b expected 0", qpi_mode); end
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] d, o;
        start_txn();
        qpi_hdr(OP_QPI_READ, 24'h000010);
        for (int i = 0; i < 7; i++) sclk_cycle(4'h0, d, o);
        n_checks++; if (d !== 4'hA) begin n_fail++; $display("FAIL rst_rd_first: got %h expected a", d); end
        n_checks++; if (data_oe !== 4'hF) begin n_fail++; $display("FAIL rst_rd_oe_pre: got %h expected f", data_oe); end
        reset = 1'b0;
        wait_clk(1);
        n_checks++; if (data_oe !== 4'h0) begin n_fail++; $display("FAIL rst_rd_oe: got %h expected 0", data_oe); end
        n_checks++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL rst_rd_qpi: got %b expected 0", qpi_mode); end
        reset = 1'b1;
        wait_clk(8);
        n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL rst_rd_no_restart: got %0d expected IDLE", dut.state); end
        cs_n = 1'b1;
        wait_clk(6);
        n_checks++; if (dut.u_array.mem[16] !== 8'hA5) begin n_fail++; $display("FAIL rst_rd_keep10: got %h expected a5", dut.u_array.mem[16]); end
        n_checks++; if (dut.u_array.mem[17] !== 8'h3C) begin n_fail++; $display("FAIL rst_rd_keep11: got %h expected 3c", dut.u_array.mem[17]); end
    endtask

    initial begin
        test_reset();
        test_spi_enable();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_qpi_exit();
        test_spi_enable();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
